// File: rtl/vxe_vpu_stor_eu.sv
//============================================================================
// Module   : vxe_vpu_stor_eu
// Brief    : VPU store execution unit. Walks the enabled VPU threads in
//            ascending order, stores each thread's accumulator to its rd
//            word address over a valid/ready request channel and, when
//            VXE_VPU_STOR_EU_RD_WB_EN is defined, post-increments the
//            thread's rd pointer through the register file write port.
// Config   : `define VXE_VPU_STOR_EU_RD_WB_EN enables the rd write-back.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module vxe_vpu_stor_eu #(
    parameter logic [2:0] RIDX_RD = 3'b010
) (
    input  wire logic         clk,
    input  wire logic         nrst,
    input  wire logic         i_start,
    output logic              o_busy,
    input  wire logic [7:0]   i_en,
    input  wire logic [255:0] i_acc,
    input  wire logic [303:0] i_rd,
    output logic              o_req_vld,
    input  wire logic         i_req_rdy,
    output logic [37:0]       o_req_addr,
    output logic [31:0]       o_req_data,
    output logic [2:0]        o_th,
    output logic [2:0]        o_ridx,
    output logic              o_wr_en,
    output logic [37:0]       o_data
);

    // Thread count is architecturally fixed
    localparam int NTHREADS = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEL  = 2'd1,
        S_REQ  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_mask;
    logic [2:0]  r_t;
    logic        r_busy;
    logic        r_vld;
    logic [37:0] r_addr;
    logic [31:0] r_dat;

    logic [37:0] w_rd_arr  [NTHREADS];
    logic [31:0] w_acc_arr [NTHREADS];
    logic [2:0]  w_sel;
    logic [7:0]  w_mask_clr;

    // Unpack the flat per-thread buses into indexable arrays
    for (genvar g = 0; g < NTHREADS; g++) begin : g_unpack
        assign w_rd_arr[g]  = i_rd[38*g +: 38];
        assign w_acc_arr[g] = i_acc[32*g +: 32];
    end

    // Lowest pending thread wins
    always_comb begin
        w_sel = 3'd0;
        for (int i = NTHREADS - 1; i >= 0; i--) begin
            if (r_mask[i]) w_sel = i[2:0];
        end
    end

    // Pending mask with the current thread retired
    assign w_mask_clr = r_mask & ~(8'd1 << r_t);

`ifdef VXE_VPU_STOR_EU_RD_WB_EN
    logic        r_wr_en;
    logic [2:0]  r_ridx;
    logic [37:0] r_wdata;
`endif

    // Sequencer: select thread, hold the store request until accepted,
    // then (optionally) write back the incremented rd pointer
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_mask  <= 8'd0;
            r_t     <= 3'd0;
            r_busy  <= 1'b0;
            r_vld   <= 1'b0;
            r_addr  <= 38'd0;
            r_dat   <= 32'd0;
`ifdef VXE_VPU_STOR_EU_RD_WB_EN
            r_wr_en <= 1'b0;
            r_ridx  <= 3'd0;
            r_wdata <= 38'd0;
`endif
        end else begin
`ifdef VXE_VPU_STOR_EU_RD_WB_EN
            r_wr_en <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mask  <= i_en;
                        r_busy  <= 1'b1;
                        r_state <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (r_mask == 8'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_t     <= w_sel;
                        r_addr  <= w_rd_arr[w_sel];
                        r_dat   <= w_acc_arr[w_sel];
                        r_vld   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_req_rdy) begin
                        r_vld  <= 1'b0;
                        r_mask <= w_mask_clr;
`ifdef VXE_VPU_STOR_EU_RD_WB_EN
                        r_wr_en <= 1'b1;
                        r_ridx  <= RIDX_RD;
                        r_wdata <= r_addr + 38'd1;
                        r_state <= S_WB;
`else
                        // Last thread done: leave without an idle SEL pass
                        if (w_mask_clr == 8'd0) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_SEL;
                        end
`endif
                    end
                end
`ifdef VXE_VPU_STOR_EU_RD_WB_EN
                S_WB: begin
                    if (r_mask == 8'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_SEL;
                    end
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_vld   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_req_vld  = r_vld;
    assign o_req_addr = r_addr;
    assign o_req_data = r_dat;

`ifdef VXE_VPU_STOR_EU_RD_WB_EN
    assign o_th    = r_t;
    assign o_ridx  = r_ridx;
    assign o_wr_en = r_wr_en;
    assign o_data  = r_wdata;
`else
    // Write-back port parked; rd pointers are left untouched
    logic w_unused;
    assign w_unused = ^RIDX_RD;
    assign o_th     = 3'd0;
    assign o_ridx   = 3'd0;
    assign o_wr_en  = 1'b0;
    assign o_data   = 38'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vxe_vpu_stor_eu.sv
//============================================================================
// Module   : tb_vxe_vpu_stor_eu
// Brief    : Self-checking bench for vxe_vpu_stor_eu (scoreboard based).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_vxe_vpu_stor_eu;

`ifdef VXE_VPU_STOR_EU_RD_WB_EN
    localparam bit WB_ON = 1'b1;
    localparam int PER   = 3;
`else
    localparam bit WB_ON = 1'b0;
    localparam int PER   = 2;
`endif

    logic         clk;
    logic         nrst;
    logic         i_start;
    logic         o_busy;
    logic [7:0]   i_en;
    logic [255:0] i_acc;
    logic [303:0] i_rd;
    logic         o_req_vld;
    logic         i_req_rdy;
    logic [37:0]  o_req_addr;
    logic [31:0]  o_req_data;
    logic [2:0]   o_th;
    logic [2:0]   o_ridx;
    logic         o_wr_en;
    logic [37:0]  o_data;

    vxe_vpu_stor_eu dut (
        .clk        (clk),
        .nrst       (nrst),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .i_en       (i_en),
        .i_acc      (i_acc),
        .i_rd       (i_rd),
        .o_req_vld  (o_req_vld),
        .i_req_rdy  (i_req_rdy),
        .o_req_addr (o_req_addr),
        .o_req_data (o_req_data),
        .o_th       (o_th),
        .o_ridx     (o_ridx),
        .o_wr_en    (o_wr_en),
        .o_data     (o_data)
    );

    typedef struct packed {
        logic [37:0] addr;
        logic [31:0] data;
        logic [2:0]  th;
    } req_t;

    typedef struct packed {
        logic [2:0]  th;
        logic [37:0] data;
    } wb_t;

    req_t q_req[$];
    wb_t  q_wb[$];

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;
    int req_seen = 0;
    int wr_seen  = 0;
    int rdy_mode = 0;   // 0: always ready, 1: 3-cycle backpressure, 2: stall on addr 0x302

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ready generator
    initial begin
        int cnt;
        cnt = 0;
        i_req_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 0) begin
                i_req_rdy = 1'b1;
            end else if (rdy_mode == 1) begin
                if (o_req_vld) begin
                    if (cnt == 3) begin
                        i_req_rdy = 1'b1;
                        cnt = 0;
                    end else begin
                        cnt++;
                        i_req_rdy = 1'b0;
                    end
                end else begin
                    i_req_rdy = 1'b0;
                    cnt = 0;
                end
            end else begin
                i_req_rdy = !(o_req_vld && o_req_addr == 38'h302);
            end
        end
    end

    // Output monitor / scoreboard consumer
    initial begin
        logic        p_vld;
        logic        p_rdy;
        logic [37:0] p_addr;
        logic [31:0] p_data;
        logic [2:0]  p_th;
        req_t r;
        wb_t  w;
        p_vld = 1'b0;
        p_rdy = 1'b0;
        p_addr = '0;
        p_data = '0;
        p_th = '0;
        forever begin
            @(negedge clk);
            if (nrst) begin
                if (o_busy) busy_cnt++;
                if (o_req_vld || o_wr_en)
                    chk("vld_wr_exclusive", {63'd0, o_req_vld & o_wr_en}, 64'd0);
                if (o_req_vld && p_vld && !p_rdy) begin
                    chk("stable_addr", {26'd0, o_req_addr}, {26'd0, p_addr});
                    chk("stable_data", {32'd0, o_req_data}, {32'd0, p_data});
                    chk("stable_th", {61'd0, o_th}, {61'd0, p_th});
                end
                if (o_req_vld && i_req_rdy) begin
                    req_seen++;
                    if (q_req.size() == 0) begin
                        chk("req_unexpected", 64'd1, 64'd0);
                    end else begin
                        r = q_req.pop_front();
                        chk("req_addr", {26'd0, o_req_addr}, {26'd0, r.addr});
                        chk("req_data", {32'd0, o_req_data}, {32'd0, r.data});
                        chk("req_th", {61'd0, o_th}, {61'd0, r.th});
                    end
                end
                if (o_wr_en) begin
                    wr_seen++;
                    if (q_wb.size() == 0) begin
                        chk("wr_unexpected", 64'd1, 64'd0);
                    end else begin
                        w = q_wb.pop_front();
                        chk("wr_th", {61'd0, o_th}, {61'd0, w.th});
                        chk("wr_ridx", {61'd0, o_ridx}, 64'd2);
                        chk("wr_data", {26'd0, o_data}, {26'd0, w.data});
                    end
                end
                p_vld  = o_req_vld;
                p_rdy  = i_req_rdy;
                p_addr = o_req_addr;
                p_data = o_req_data;
                p_th   = o_th;
            end else begin
                p_vld = 1'b0;
            end
        end
    end

    task automatic set_thread(input int n, input logic [31:0] acc, input logic [37:0] rd);
        i_acc[32*n +: 32] = acc;
        i_rd[38*n +: 38]  = rd;
    endtask

    // Model: one store per enabled thread in ascending order, rd+1 write-back
    task automatic push_expect(input logic [7:0] en);
        req_t r;
        wb_t  w;
        for (int n = 0; n < 8; n++) begin
            if (en[n]) begin
                r.addr = i_rd[38*n +: 38];
                r.data = i_acc[32*n +: 32];
                r.th   = WB_ON ? n[2:0] : 3'd0;
                q_req.push_back(r);
                if (WB_ON) begin
                    w.th   = n[2:0];
                    w.data = r.addr + 38'd1;
                    q_wb.push_back(w);
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!o_busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_req_left"}, 64'(q_req.size()), 64'd0);
        chk({tag, "_wb_left"}, 64'(q_wb.size()), 64'd0);
    endtask

    initial begin
        int rs;
        int ws;
        bit hit;
        nrst    = 1'b0;
        i_start = 1'b0;
        i_en    = 8'd0;
        i_acc   = '0;
        i_rd    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {o_busy, o_req_vld, o_wr_en, o_th, o_ridx, o_req_addr[14:0]}, 64'd0);
        chk("reset_addr_data", {o_req_data, o_data[31:0]}, 64'd0);
        nrst = 1'b1;
        repeat (2) @(posedge clk);

        // Single thread
        set_thread(0, 32'h3F800000, 38'h100);
        i_en = 8'h01;
        push_expect(i_en);
        busy_cnt = 0;
        pulse_start();
        wait_idle(50);
        chk("single_busy", 64'(busy_cnt), 64'(PER));
        check_drained("single");

        // All threads
        for (int n = 0; n < 8; n++) set_thread(n, 32'h7F800000, 38'(16 * n));
        i_en = 8'hFF;
        push_expect(i_en);
        busy_cnt = 0;
        rs = req_seen;
        pulse_start();
        wait_idle(200);
        chk("all_busy", 64'(busy_cnt), 64'(8 * PER));
        chk("all_stores", 64'(req_seen - rs), 64'd8);
        check_drained("all");

        // Sparse mask with backpressure
        for (int n = 0; n < 8; n++) set_thread(n, 32'h41800000, 38'h200 + 38'(n));
        i_en = 8'b11100111;
        push_expect(i_en);
        rs = req_seen;
        rdy_mode = 1;
        pulse_start();
        wait_idle(300);
        rdy_mode = 0;
        chk("sparse_stores", 64'(req_seen - rs), 64'd6);
        check_drained("sparse");

        // Zero mask
        i_en = 8'h00;
        busy_cnt = 0;
        rs = req_seen;
        ws = wr_seen;
        pulse_start();
        wait_idle(20);
        repeat (2) @(negedge clk);
        chk("zero_busy", 64'(busy_cnt), 64'd1);
        chk("zero_events", 64'((req_seen - rs) + (wr_seen - ws)), 64'd0);

        // Start while busy is ignored
        for (int n = 0; n < 8; n++) set_thread(n, 32'hC0000000 + 32'(n), 38'h400 + 38'(n));
        i_en = 8'h05;
        push_expect(i_en);
        busy_cnt = 0;
        rs = req_seen;
        pulse_start();
        i_en = 8'hFF;
        @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        wait_idle(100);
        repeat (3) @(negedge clk);
        chk("restart_busy", 64'(busy_cnt), 64'(2 * PER));
        chk("restart_stores", 64'(req_seen - rs), 64'd2);
        check_drained("restart");

        // rd pointer wrap
        set_thread(7, 32'h12345678, 38'h3FFFFFFFFF);
        i_en = 8'h80;
        push_expect(i_en);
        pulse_start();
        wait_idle(50);
        check_drained("wrap");

        // Reset while thread 2 is stalled in REQ
        for (int n = 0; n < 8; n++) set_thread(n, 32'hA5A50000 + 32'(n), 38'h300 + 38'(n));
        i_en = 8'h07;
        push_expect(i_en);
        rdy_mode = 2;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_req_vld && o_req_addr == 38'h302) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rst_reached_thread2", {63'd0, hit}, 64'd1);
        #2 nrst = 1'b0;
        #1;
        chk("rst_ctrl_zero", {o_busy, o_req_vld, o_wr_en, o_th, o_ridx}, 64'd0);
        chk("rst_addr_zero", {26'd0, o_req_addr}, 64'd0);
        chk("rst_data_zero", {o_req_data, 32'd0}, 64'd0);
        chk("rst_wdata_zero", {26'd0, o_data}, 64'd0);
        q_req.delete();
        q_wb.delete();
        rdy_mode = 0;
        @(posedge clk);
        #3 nrst = 1'b1;
        busy_cnt = 0;
        rs = req_seen;
        ws = wr_seen;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", 64'(busy_cnt + (req_seen - rs) + (wr_seen - ws)), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/vxe_vpu_stor_eu.md
Name: vxe_vpu_stor_eu

Overview:
VPU store execution unit; the consumer of the per-thread accumulators after the activation function unit has written them back.
- On start, walks the 8 VPU threads in ascending order and skips disabled threads.
- For each enabled thread, issues one 32-bit word store (accumulator value to the thread's rd word address) on a valid/ready memory request channel.
- After each store, post-increments the thread's rd pointer through the same register file write interface the other VPU execution units use.

Parameters:
- RIDX_RD, 3'b010, register file index of the rd pointer register used for write-back.
- NTHREADS, 8, number of VPU threads; fixed, not to be overridden.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- i_start  in  1  start pulse from control unit
- o_busy  out  1  unit busy
- i_en  in  8  thread enable mask, bit N = thread N
- i_acc  in  256  thread accumulators, thread N at [32N+31:32N], FP32
- i_rd  in  304  thread rd word addresses, thread N at [38N+37:38N]
- o_req_vld  out  1  store request valid
- i_req_rdy  in  1  store request accepted
- o_req_addr  out  38  store word address
- o_req_data  out  32  store data
- o_th  out  3  register file thread index
- o_ridx  out  3  register file register index (always RIDX_RD)
- o_wr_en  out  1  register file write enable
- o_data  out  38  register file write data

Behaviour:
- Reset: clock domain and reset are fixed as one clock, clk; reset nrst is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; pending mask 0.
- States:
  - IDLE: o_busy=0. i_start=1 latches i_en into the pending mask and moves to SEL. o_busy=1 from the next cycle.
  - SEL: mask==0 goes to IDLE (o_busy=0 next cycle). Otherwise selects the lowest set bit t, registers addr=i_rd[t] and data=i_acc[t], and goes to REQ. Inputs are sampled here, once per thread.
  - REQ: o_req_vld=1; o_req_addr, o_req_data and o_th=t held stable until i_req_rdy=1. The handshake completes on the cycle vld&rdy; that cycle clears bit t and goes to WB.
  - WB: one cycle with o_wr_en=1, o_th=t, o_ridx=RIDX_RD, o_data=addr+1 (mod 2^38; 38'h3FFFFFFFFF wraps to 0). Then goes to SEL.
- Per-thread latency with i_req_rdy held 1: SEL, REQ, WB = 3 cycles.
- Zero-thread start: busy high exactly 1 cycle (SEL), with no requests and no writes.
- i_start while busy: ignored; mask is not re-latched.
- i_en changes after start: ignored until the next start.
- o_req_vld is never withdrawn before acceptance. i_req_rdy while not in REQ is ignored.
- o_wr_en is never asserted in the same cycle as o_req_vld.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no partial write.

Optional Feature:
- Macro VXE_VPU_STOR_EU_RD_WB_EN.
- Defined: rd post-increment write-back as described, via the WB state.
- Not defined:
  - WB state removed; REQ handshake goes directly to SEL (2 cycles per thread).
  - o_wr_en, o_th, o_ridx and o_data tied to 0.
  - rd pointers are left unchanged.

Test Plan:
- Single thread: i_en=8'h01, acc0=32'h3F800000, rd0=38'h100, rdy=1, start pulse -> one request addr=38'h100, data=32'h3F800000. Then, with the macro defined, a write th=0, ridx=3'b010, data=38'h101. Busy high 3 cycles.
- All threads: i_en=8'hFF, accN=32'h7F800000, rdN=38'h10*N, rdy=1 -> 8 requests in thread order 0..7, addresses 0x00,0x10,...,0x70, each followed by a write of rdN+1. Busy 24 cycles (16 with the macro undefined).
- Sparse mask with backpressure: i_en=8'b11100111, acc=32'h41800000, rdy low 3 cycles per request -> threads 3 and 4 skipped. Request fields stable while vld&!rdy. 6 stores total.
- Zero mask and start while busy: i_en=0 start -> busy 1 cycle, no vld/wr_en. A second start issued mid-run with i_en=8'hFF is ignored; only the original mask is stored.
- Wrap: rd7=38'h3FFFFFFFFF, i_en=8'h80 -> request addr 38'h3FFFFFFFFF, write-back data 38'h0, o_th=7.
- Reset mid-run: nrst low while in REQ of thread 2 -> all outputs 0 immediately. After release, idle until the next start.
